hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage core. It sits beside the EX-stage forwarding unit and covers the hazards that forwarding cannot resolve. It generates stall, bubble, hold and flush controls for the IF/ID and ID/EX pipeline registers. Three cases are sequenced:
- load-use dependencies;
- multi-cycle multiply/divide occupancy of EX;
- taken-branch squashes.

It also keeps saturating stall and flush performance counters.

---
 rtl/hazard_ctrl_if.sv | 39 +++
 rtl/hazard_ctrl.sv | 92 +++++++++
 tb/tb_hazard_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: hazard controller signal bundle.
// master = pipeline side, slave = hazard controller.
interface hazard_ctrl_if;
  logic [3:0]  RA1_ID;
  logic [3:0]  RA2_ID;
  logic        Use1_ID;
  logic        Use2_ID;
  logic [3:0]  RA1_EX;
  logic        RegWrite_EX;
  logic        MemRead_EX;
  logic        MulOp_EX;
  logic        BranchTaken_EX;
  logic        Stall_IF;
  logic        Stall_ID;
  logic        Bubble_EX;
  logic        Flush_ID;
  logic        Hold_EX;
  logic        Busy;
  logic [15:0] StallCnt;
  logic [15:0] FlushCnt;

  modport master (
    output RA1_ID, RA2_ID, Use1_ID, Use2_ID,
    output RA1_EX, RegWrite_EX, MemRead_EX,
    output MulOp_EX, BranchTaken_EX,
    input  Stall_IF, Stall_ID, Bubble_EX,
    input  Flush_ID, Hold_EX, Busy,
    input  StallCnt, FlushCnt
  );

  modport slave (
    input  RA1_ID, RA2_ID, Use1_ID, Use2_ID,
    input  RA1_EX, RegWrite_EX, MemRead_EX,
    input  MulOp_EX, BranchTaken_EX,
    output Stall_IF, Stall_ID, Bubble_EX,
    output Flush_ID, Hold_EX, Busy,
    output StallCnt, FlushCnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use, mul/div occupancy and branch
// squash sequencing for IF/ID and ID/EX, plus perf counters.
module hazard_ctrl #(
  parameter int unsigned MUL_CYCLES = 4
) (
  input logic         clk,
  input logic         rst_n,
  hazard_ctrl_if.slave hz
);

  typedef enum logic {RUN, MULW} state_e;

  localparam logic [3:0] MulLast = 4'(MUL_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  logic stall, bubble, flush, hold;
  logic lu_haz;

  assign lu_haz = hz.MemRead_EX & hz.RegWrite_EX &
    ((hz.Use1_ID & (hz.RA1_ID == hz.RA1_EX)) |
     (hz.Use2_ID & (hz.RA2_ID == hz.RA1_EX)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    bubble  = 1'b0;
    flush   = 1'b0;
    hold    = 1'b0;
    unique case (state_q)
      RUN: begin
        if (hz.BranchTaken_EX) begin
          flush  = 1'b1;
          bubble = 1'b1;
        end else if (hz.MulOp_EX) begin
          stall   = 1'b1;
          hold    = 1'b1;
          cnt_d   = MulLast;
          state_d = MULW;
        end else if (lu_haz) begin
          stall  = 1'b1;
          bubble = 1'b1;
        end
      end
      MULW: begin
        if (cnt_q > 4'd1) begin
          stall = 1'b1;
          hold  = 1'b1;
          cnt_d = cnt_q - 4'd1;
        end else begin
          cnt_d   = 4'd0;
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Controls are forced low for the whole time reset is held.
  assign hz.Stall_IF  = rst_n & stall;
  assign hz.Stall_ID  = rst_n & stall;
  assign hz.Bubble_EX = rst_n & bubble;
  assign hz.Flush_ID  = rst_n & flush;
  assign hz.Hold_EX   = rst_n & hold;
  assign hz.Busy      = rst_n & (state_q == MULW);
  assign hz.StallCnt  = stall_cnt_q;
  assign hz.FlushCnt  = flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      cnt_q       <= 4'd0;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (stall && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
      if (flush && flush_cnt_q != 16'hFFFF)
        flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of hazard_ctrl with
// MUL_CYCLES=4 (a) and MUL_CYCLES=2 (b) on shared inputs.
module tb_hazard_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  hazard_ctrl_if ia ();
  hazard_ctrl_if ib ();

  assign ib.RA1_ID         = ia.RA1_ID;
  assign ib.RA2_ID         = ia.RA2_ID;
  assign ib.Use1_ID        = ia.Use1_ID;
  assign ib.Use2_ID        = ia.Use2_ID;
  assign ib.RA1_EX         = ia.RA1_EX;
  assign ib.RegWrite_EX    = ia.RegWrite_EX;
  assign ib.MemRead_EX     = ia.MemRead_EX;
  assign ib.MulOp_EX       = ia.MulOp_EX;
  assign ib.BranchTaken_EX = ia.BranchTaken_EX;

  hazard_ctrl #(.MUL_CYCLES(4)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (ia.slave)
  );

  hazard_ctrl #(.MUL_CYCLES(2)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (ib.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ia.RA1_ID         = 4'd0;
    ia.RA2_ID         = 4'd0;
    ia.Use1_ID        = 1'b0;
    ia.Use2_ID        = 1'b0;
    ia.RA1_EX         = 4'd0;
    ia.RegWrite_EX    = 1'b0;
    ia.MemRead_EX     = 1'b0;
    ia.MulOp_EX       = 1'b0;
    ia.BranchTaken_EX = 1'b0;
  endtask

  task automatic load_use(input logic [3:0] rd,
                          input logic [3:0] r1, input logic u1,
                          input logic [3:0] r2, input logic u2,
                          input logic mr, input logic rw);
    ia.RA1_EX      = rd;
    ia.RA1_ID      = r1;
    ia.Use1_ID     = u1;
    ia.RA2_ID      = r2;
    ia.Use2_ID     = u2;
    ia.MemRead_EX  = mr;
    ia.RegWrite_EX = rw;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle();
    #12;
    check("rst_busy", 32'(ia.Busy), 32'd0);
    check("rst_stallcnt", 32'(ia.StallCnt), 32'd0);
    check("rst_flushcnt", 32'(ia.FlushCnt), 32'd0);
    ia.MulOp_EX = 1'b1;
    ia.BranchTaken_EX = 1'b1;
    #1;
    check("rst_forced_hold", 32'(ia.Hold_EX), 32'd0);
    check("rst_forced_flush", 32'(ia.Flush_ID), 32'd0);
    check("rst_forced_bubble", 32'(ia.Bubble_EX), 32'd0);
    idle();
    #5;
    rst_n = 1'b1;
    tick();

    // load-use on rs2
    load_use(4'd5, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1, 1'b1);
    #1;
    check("lu_stall_if", 32'(ia.Stall_IF), 32'd1);
    check("lu_stall_id", 32'(ia.Stall_ID), 32'd1);
    check("lu_bubble", 32'(ia.Bubble_EX), 32'd1);
    check("lu_hold", 32'(ia.Hold_EX), 32'd0);
    check("lu_flush", 32'(ia.Flush_ID), 32'd0);
    tick();
    idle();
    #1;
    check("lu_one_cycle", 32'(ia.Stall_IF), 32'd0);
    check("lu_stallcnt", 32'(ia.StallCnt), 32'd1);
    // same but rs2 not used
    load_use(4'd5, 4'd0, 1'b0, 4'd5, 1'b0, 1'b1, 1'b1);
    #1;
    check("lu_nouse", 32'(ia.Stall_IF), 32'd0);
    check("lu_nouse_bub", 32'(ia.Bubble_EX), 32'd0);
    tick();
    // R0 on rs1 is compared like any register
    load_use(4'd0, 4'd0, 1'b1, 4'd7, 1'b0, 1'b1, 1'b1);
    #1;
    check("lu_r0", 32'(ia.Stall_IF), 32'd1);
    tick();
    // not a load
    load_use(4'd3, 4'd3, 1'b1, 4'd3, 1'b1, 1'b0, 1'b1);
    #1;
    check("lu_noload", 32'(ia.Stall_IF), 32'd0);
    tick();
    // no write-back
    load_use(4'd3, 4'd3, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0);
    #1;
    check("lu_nowrite", 32'(ia.Stall_IF), 32'd0);
    tick();
    idle();
    #1;
    check("lu_cnt_a", 32'(ia.StallCnt), 32'd2);
    check("lu_cnt_b", 32'(ib.StallCnt), 32'd2);

    // mul/div held high for 4 cycles: a holds 3, b runs twice
    ia.MulOp_EX = 1'b1;
    #1;
    check("m1_hold_a", 32'(ia.Hold_EX), 32'd1);
    check("m1_stall_a", 32'(ia.Stall_IF), 32'd1);
    check("m1_busy_a", 32'(ia.Busy), 32'd0);
    check("m1_hold_b", 32'(ib.Hold_EX), 32'd1);
    tick();
    load_use(4'd5, 4'd5, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1);
    #1;
    check("m2_hold_a", 32'(ia.Hold_EX), 32'd1);
    check("m2_busy_a", 32'(ia.Busy), 32'd1);
    check("m2_lu_ign_a", 32'(ia.Bubble_EX), 32'd0);
    check("m2_hold_b", 32'(ib.Hold_EX), 32'd0);
    check("m2_stall_b", 32'(ib.Stall_IF), 32'd0);
    check("m2_busy_b", 32'(ib.Busy), 32'd1);
    check("m2_lu_ign_b", 32'(ib.Bubble_EX), 32'd0);
    tick();
    idle();
    ia.MulOp_EX = 1'b1;
    #1;
    check("m3_hold_a", 32'(ia.Hold_EX), 32'd1);
    check("m3_busy_a", 32'(ia.Busy), 32'd1);
    check("m3_hold_b", 32'(ib.Hold_EX), 32'd1);
    check("m3_busy_b", 32'(ib.Busy), 32'd0);
    tick();
    #1;
    check("m4_hold_a", 32'(ia.Hold_EX), 32'd0);
    check("m4_stall_a", 32'(ia.Stall_IF), 32'd0);
    check("m4_busy_a", 32'(ia.Busy), 32'd1);
    check("m4_hold_b", 32'(ib.Hold_EX), 32'd0);
    check("m4_busy_b", 32'(ib.Busy), 32'd1);
    tick();
    idle();
    #1;
    check("m_done_busy_a", 32'(ia.Busy), 32'd0);
    check("m_done_busy_b", 32'(ib.Busy), 32'd0);
    check("m_cnt_a", 32'(ia.StallCnt), 32'd5);
    check("m_cnt_b", 32'(ib.StallCnt), 32'd4);

    // branch beats load-use
    load_use(4'd5, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1, 1'b1);
    ia.BranchTaken_EX = 1'b1;
    #1;
    check("br_flush", 32'(ia.Flush_ID), 32'd1);
    check("br_bubble", 32'(ia.Bubble_EX), 32'd1);
    check("br_stall_if", 32'(ia.Stall_IF), 32'd0);
    check("br_stall_id", 32'(ia.Stall_ID), 32'd0);
    tick();
    idle();
    #1;
    check("br_one_cycle", 32'(ia.Flush_ID), 32'd0);
    check("br_flushcnt", 32'(ia.FlushCnt), 32'd1);
    check("br_stallcnt", 32'(ia.StallCnt), 32'd5);
    // branch beats mul/div start
    ia.BranchTaken_EX = 1'b1;
    ia.MulOp_EX = 1'b1;
    #1;
    check("brm_hold", 32'(ia.Hold_EX), 32'd0);
    check("brm_flush", 32'(ia.Flush_ID), 32'd1);
    tick();
    idle();
    #1;
    check("brm_busy", 32'(ia.Busy), 32'd0);
    check("brm_flushcnt", 32'(ia.FlushCnt), 32'd2);

    // reset in the second MULW cycle
    ia.MulOp_EX = 1'b1;
    tick();
    tick();
    #1;
    check("rm_busy_pre", 32'(ia.Busy), 32'd1);
    check("rm_hold_pre", 32'(ia.Hold_EX), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rm_busy", 32'(ia.Busy), 32'd0);
    check("rm_hold", 32'(ia.Hold_EX), 32'd0);
    check("rm_stallcnt", 32'(ia.StallCnt), 32'd0);
    check("rm_flushcnt", 32'(ia.FlushCnt), 32'd0);
    ia.MulOp_EX = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    #1;
    check("rm_post_busy", 32'(ia.Busy), 32'd0);
    check("rm_post_hold", 32'(ia.Hold_EX), 32'd0);
    check("rm_post_stall", 32'(ia.Stall_IF), 32'd0);
    tick();
    check("rm_post_busy2", 32'(ia.Busy), 32'd0);

    // saturation of the stall counter
    load_use(4'd9, 4'd9, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1);
    repeat (70000) tick();
    check("sat_a", 32'(ia.StallCnt), 32'hFFFF);
    check("sat_b", 32'(ib.StallCnt), 32'hFFFF);
    check("sat_still_stall", 32'(ia.Stall_IF), 32'd1);
    repeat (3) tick();
    check("sat_hold", 32'(ia.StallCnt), 32'hFFFF);
    idle();
    tick();
    check("sat_idle", 32'(ia.StallCnt), 32'hFFFF);
    check("sat_flushcnt", 32'(ia.FlushCnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
